icdf_stat_acc: RTL

Downstream consumer of the Sobol/ICDF Gaussian generator. Accepts the 16-bit signed ICDF sample stream and accumulates a window of 2^LOG2_N samples into a sum and a sum of squares. It then presents the window mean and mean-square on a valid/ready output. The block is used for on-chip self-check of the generated distribution: mean ≈ 0, mean-square ≈ variance.

---
 rtl/icdf_stat_acc.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/icdf_stat_acc.sv
// Window statistics over the ICDF Gaussian sample stream: mean, mean-square and,
// with STAT_MINMAX_EN defined, min/max over 2^LOG2_N samples.
module icdf_stat_acc #(
  parameter int unsigned LOG2_N = 10,
  parameter int unsigned DW     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_mean,
  output logic [2*DW-1:0]   out_meansq,
  output logic [DW-1:0]     out_min,
  output logic [DW-1:0]     out_max
);

  localparam int unsigned N  = 1 << LOG2_N;
  localparam int unsigned CW = LOG2_N + 1;
  localparam int unsigned SW = DW + LOG2_N;
  localparam int unsigned QW = 2 * DW - 1 + LOG2_N;
  localparam int unsigned PW = 2 * DW;

  typedef enum logic [1:0] {IDLE, ACC, FLUSH, DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   s1_valid;
  logic signed [DW-1:0]   s1_data;
  logic [PW-1:0]          s1_sq;
  logic signed [SW-1:0]   sum;
  logic [QW-1:0]          sumsq;
  logic                   accept;
  logic                   clear;
  logic signed [PW-1:0]   din_ext;
  logic signed [PW-1:0]   sq_full;

  assign in_ready = (state == ACC);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  // New window either from IDLE or straight out of DONE on a same-cycle handshake
  assign clear    = start && ((state == IDLE) || (state == DONE && out_valid && out_ready));
  assign din_ext  = PW'($signed(in_data));
  assign sq_full  = din_ext * din_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_sq      <= '0;
      sum        <= '0;
      sumsq      <= '0;
      out_valid  <= 1'b0;
      out_mean   <= '0;
      out_meansq <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= in_data;
        s1_sq   <= PW'($unsigned(sq_full));
      end

      if (clear) begin
        sum   <= '0;
        sumsq <= '0;
      end else if (s1_valid) begin
        sum   <= sum + SW'(s1_data);
        sumsq <= sumsq + QW'(s1_sq);
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= ACC;
            cnt   <= '0;
          end
        end
        ACC: begin
          if (accept) begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(N - 1)) state <= FLUSH;
          end
        end
        FLUSH: state <= DONE;
        DONE: begin
          // First DONE cycle captures the settled accumulators; handshake follows
          if (!out_valid) begin
            out_valid  <= 1'b1;
            out_mean   <= DW'(sum >>> LOG2_N);
            out_meansq <= PW'(sumsq >> LOG2_N);
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (start) begin
              state <= ACC;
              cnt   <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STAT_MINMAX_EN
  logic signed [DW-1:0] run_min;
  logic signed [DW-1:0] run_max;
  logic                 first;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_min <= '0;
      run_max <= '0;
      first   <= 1'b1;
      out_min <= '0;
      out_max <= '0;
    end else begin
      if (clear) begin
        run_min <= '0;
        run_max <= '0;
        first   <= 1'b1;
      end else if (s1_valid) begin
        first <= 1'b0;
        if (first || s1_data < run_min) run_min <= s1_data;
        if (first || s1_data > run_max) run_max <= s1_data;
      end
      if (state == DONE && !out_valid) begin
        out_min <= run_min;
        out_max <= run_max;
      end
    end
  end
`else
  assign out_min = '0;
  assign out_max = '0;
`endif

endmodule
